// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;
  localparam int N_DEF = 8;
  localparam int A_DEF = 2;

  // Busy count must hold the full depth, so one bit wider than the address.
  function automatic int cnt_w(input int a);
    return a + 1;
  endfunction
endpackage

// File: rtl/regfile_sb_bits.sv
// Scoreboard: one busy bit per register plus a registered population count.
module sb_bits
  import regfile_pkg::*;
#(
  parameter int A       = A_DEF,
  parameter bit ZERO_R0 = 1'b0,
  localparam int D      = 2**A,
  localparam int CW     = cnt_w(A)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [A-1:0]  wr_num,
  input  logic          rsv_en,
  input  logic [A-1:0]  rsv_num,
  output logic          rsv_ok,
  output logic [D-1:0]  busy,
  output logic [CW-1:0] busy_cnt
);

  logic [D-1:0]  busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsv_hit_wr, rsv_fire, inc, dec;

  always_comb begin
    rsv_hit_wr = wr_en && (wr_num == rsv_num);
    rsv_ok     = !busy_q[rsv_num] || rsv_hit_wr;
    if (ZERO_R0 && (rsv_num == '0)) rsv_ok = 1'b0;
    rsv_fire   = rsv_en && rsv_ok;
    // Same-index clear+set leaves the bit set, so only a genuinely new bit counts up
    // and a clear that is overridden by the set does not count down.
    inc        = rsv_fire && !busy_q[rsv_num];
    dec        = wr_en && busy_q[wr_num] && !(rsv_fire && rsv_hit_wr);
    cnt_d      = cnt_q + CW'(inc) - CW'(dec);
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < D; i++) begin
      if (wr_en && (wr_num == A'(i)))     busy_d[i] = 1'b0;
      if (rsv_fire && (rsv_num == A'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with write bypass and a reservation scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int A       = A_DEF,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [A-1:0] wr_num,
  input  logic [N-1:0] wr_data,
  input  logic [A-1:0] rd0_num,
  input  logic [A-1:0] rd1_num,
  output logic [N-1:0] rd0_data,
  output logic [N-1:0] rd1_data,
  output logic         rd0_busy,
  output logic         rd1_busy,
  input  logic         rsv_en,
  input  logic [A-1:0] rsv_num,
  output logic         rsv_ok,
  output logic [A:0]   busy_cnt
);

  localparam int D = 2**A;

  logic [D-1:0][N-1:0] data_q, data_d;
  logic [D-1:0]        busy;
  logic [1:0][A-1:0]   rd_num;
  logic [1:0][N-1:0]   rd_data;
  logic [1:0]          rd_busy;

  sb_bits #(.A(A), .ZERO_R0(ZERO_R0)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_num   (wr_num),
    .rsv_en   (rsv_en),
    .rsv_num  (rsv_num),
    .rsv_ok   (rsv_ok),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    data_d = data_q;
    if (wr_en && !(ZERO_R0 && (wr_num == '0))) data_d[wr_num] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign rd_num = {rd1_num, rd0_num};

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = data_q[rd_num[p]];
      rd_busy[p] = busy[rd_num[p]];
      if (BYPASS && wr_en && (wr_num == rd_num[p])) begin
        rd_data[p] = wr_data;
        rd_busy[p] = 1'b0;
      end
      // Hard-wired zero register wins over the bypass path.
      if (ZERO_R0 && (rd_num[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd0_data = rd_data[0];
  assign rd1_data = rd_data[1];
  assign rd0_busy = rd_busy[0];
  assign rd1_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: three configs (default, no bypass, zero r0) share one stimulus stream.
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rsv_en = 1'b0;
  logic [1:0] wr_num = '0, rsv_num = '0, rd0_num = '0, rd1_num = '0;
  logic [7:0] wr_data = '0;

  logic [2:0][7:0] rd0_d, rd1_d;
  logic [2:0]      rd0_b, rd1_b, ok;
  logic [2:0][2:0] cnt;

  always #5 clk = ~clk;

  regfile_sb #(.N(8), .A(2), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .rd0_num(rd0_num), .rd1_num(rd1_num), .rd0_data(rd0_d[0]), .rd1_data(rd1_d[0]),
    .rd0_busy(rd0_b[0]), .rd1_busy(rd1_b[0]), .rsv_en(rsv_en), .rsv_num(rsv_num),
    .rsv_ok(ok[0]), .busy_cnt(cnt[0]));

  regfile_sb #(.N(8), .A(2), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .rd0_num(rd0_num), .rd1_num(rd1_num), .rd0_data(rd0_d[1]), .rd1_data(rd1_d[1]),
    .rd0_busy(rd0_b[1]), .rd1_busy(rd1_b[1]), .rsv_en(rsv_en), .rsv_num(rsv_num),
    .rsv_ok(ok[1]), .busy_cnt(cnt[1]));

  regfile_sb #(.N(8), .A(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .rd0_num(rd0_num), .rd1_num(rd1_num), .rd0_data(rd0_d[2]), .rd1_data(rd1_d[2]),
    .rd0_busy(rd0_b[2]), .rd1_busy(rd1_b[2]), .rsv_en(rsv_en), .rsv_num(rsv_num),
    .rsv_ok(ok[2]), .busy_cnt(cnt[2]));

  // Config table: index 0 default, 1 bypass off, 2 zero-register on.
  bit   cfg_byp [3] = '{1'b1, 1'b0, 1'b1};
  bit   cfg_zero[3] = '{1'b0, 1'b0, 1'b1};

  logic [7:0] md[3][4];
  logic       mb[3][4];

  logic [21:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, n_step = 0;

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (rd0,rd1,b0,b1,ok,cnt)", tag, got, exp);
    end
  endtask

  function automatic logic m_ok(input int c);
    if (cfg_zero[c] && rsv_num == 2'd0) return 1'b0;
    return !mb[c][rsv_num] || (wr_en && wr_num == rsv_num);
  endfunction

  function automatic logic [7:0] m_rd(input int c, input logic [1:0] n);
    if (cfg_zero[c] && n == 2'd0) return 8'h00;
    if (cfg_byp[c] && wr_en && wr_num == n) return wr_data;
    return md[c][n];
  endfunction

  function automatic logic m_rb(input int c, input logic [1:0] n);
    if (cfg_zero[c] && n == 2'd0) return 1'b0;
    if (cfg_byp[c] && wr_en && wr_num == n) return 1'b0;
    return mb[c][n];
  endfunction

  function automatic logic [2:0] m_cnt(input int c);
    logic [2:0] s = '0;
    for (int i = 0; i < 4; i++) s += {2'b0, mb[c][i]};
    return s;
  endfunction

  function automatic logic [21:0] m_exp(input int c);
    return {m_rd(c, rd0_num), m_rd(c, rd1_num), m_rb(c, rd0_num), m_rb(c, rd1_num), m_ok(c), m_cnt(c)};
  endfunction

  function automatic logic [21:0] obs(input int c);
    return {rd0_d[c], rd1_d[c], rd0_b[c], rd1_b[c], ok[c], cnt[c]};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 4; i++) begin
        md[c][i] = 8'h00;
        mb[c][i] = 1'b0;
      end
  endtask

  task automatic push_and_check();
    for (int c = 0; c < 3; c++) exp_q.push_back(m_exp(c));
    #1;
    for (int c = 0; c < 3; c++) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow step%0d cfg%0d", n_step, c);
      end else
        chk($sformatf("step%0d/cfg%0d", n_step, c), obs(c), exp_q.pop_front());
    end
    n_step++;
  endtask

  task automatic step(input logic we, input logic [1:0] wn, input logic [7:0] wd,
                      input logic re, input logic [1:0] rn,
                      input logic [1:0] r0, input logic [1:0] r1);
    logic okv[3];
    @(negedge clk);
    wr_en = we; wr_num = wn; wr_data = wd;
    rsv_en = re; rsv_num = rn; rd0_num = r0; rd1_num = r1;
    push_and_check();
    for (int c = 0; c < 3; c++) okv[c] = m_ok(c);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (we && !(cfg_zero[c] && wn == 2'd0)) md[c][wn] = wd;
      if (we) mb[c][wn] = 1'b0;
      if (re && okv[c]) mb[c][rn] = 1'b1;
    end
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset reads of every register.
    step(0, 0, 8'h00, 0, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 2, 3);
    // Write with same-cycle read, then read back.
    step(1, 2, 8'hA5, 0, 0, 2, 0);
    step(0, 0, 8'h00, 0, 0, 2, 1);
    // Reserve r1, retry (refused), then write clears it.
    step(0, 0, 8'h00, 1, 1, 0, 1);
    step(0, 0, 8'h00, 1, 1, 0, 1);
    step(0, 0, 8'h00, 0, 0, 2, 1);
    step(1, 1, 8'h3C, 0, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 2, 1);
    // Same-index write and reservation: set wins.
    step(0, 0, 8'h00, 1, 3, 3, 3);
    step(1, 3, 8'h77, 1, 3, 3, 2);
    step(0, 0, 8'h00, 0, 0, 3, 3);
    step(1, 3, 8'h78, 0, 0, 0, 3);
    // Register 0 write and reservation.
    step(1, 0, 8'hFF, 1, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0, 1);
    step(1, 0, 8'h12, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Fill the scoreboard then reset asynchronously between edges.
    step(0, 0, 8'h00, 1, 0, 0, 1);
    step(0, 0, 8'h00, 1, 1, 2, 3);
    step(0, 0, 8'h00, 1, 2, 0, 1);
    step(0, 0, 8'h00, 1, 3, 2, 3);
    @(negedge clk);
    wr_en = 1'b0; rsv_en = 1'b0; rd0_num = 2'd2; rd1_num = 2'd3;
    #2 rst_n = 1'b0;
    m_reset();
    push_and_check();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release behaves normally.
    step(1, 1, 8'h11, 1, 2, 1, 2);
    step(0, 0, 8'h00, 0, 0, 1, 2);

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_leftover: %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
